// File: rtl/cordic_ci_sequencer.sv
// cordic_ci_sequencer: Nios II multi-cycle custom-instruction controller for the CORDIC cosine chain
module cordic_ci_sequencer #(
  parameter int N_ITER  = 16,
  parameter int IDX_W   = 5,
  parameter int ANGLE_W = 21,
  parameter int RES_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               start,
  input  logic [31:0]        dataa,
  output logic               done,
  output logic [RES_W-1:0]   result,
  output logic               busy,
  output logic [31:0]        conv_in,
  input  logic [ANGLE_W-1:0] conv_angle,
  output logic               core_load,
  output logic [ANGLE_W-1:0] core_angle,
  output logic               core_step,
  output logic [IDX_W-1:0]   core_iter,
  input  logic [RES_W-1:0]   core_cos
);
  typedef enum logic [2:0] {IDLE, CONV, LOAD, ITER, FINISH} state_t;
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   iter_q, iter_d;
  logic [31:0]        conv_q, conv_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               done_q, done_d;
  // Next-state logic; everything freezes while the custom-instruction clock enable is low
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    conv_d   = conv_q;
    angle_d  = angle_q;
    result_d = result_q;
    done_d   = done_q;
    if (clk_en) begin
      done_d = state_q == FINISH;
      case (state_q)
        IDLE: if (start) begin
          conv_d  = dataa;
          state_d = CONV;
        end
        CONV: begin
          angle_d = conv_angle;
          state_d = LOAD;
        end
        LOAD: begin
          iter_d  = '0;
          state_d = ITER;
        end
        ITER: begin
          state_d = iter_q == IDX_W'(N_ITER - 1) ? FINISH : ITER;
          iter_d  = iter_q == IDX_W'(N_ITER - 1) ? iter_q : iter_q + IDX_W'(1);
        end
        FINISH: begin
          result_d = core_cos;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // State and datapath registers with asynchronous active-low abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      iter_q   <= '0;
      conv_q   <= '0;
      angle_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      conv_q   <= conv_d;
      angle_q  <= angle_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end
  assign done       = done_q & clk_en;
  assign core_load  = (state_q == LOAD) & clk_en;
  assign core_step  = (state_q == ITER) & clk_en;
  assign busy       = state_q != IDLE;
  assign result     = result_q;
  assign conv_in    = conv_q;
  assign core_angle = angle_q;
  assign core_iter  = iter_q;
endmodule

// File: doc/cordic_ci_sequencer.md
Name: cordic_ci_sequencer

Overview:
- Multi-cycle Nios II custom-instruction controller for the cosine accelerator.
- Accepts a float operand on dataa and sequences it through the external chain: float-to-fixed 8.13 converter, fixed subtract/divide-by-128 stage, then an iterative CORDIC core.
- After the last iteration it captures the core's float result and returns it with a one-cycle done pulse.
- Owns the handshake, the iteration counter and the load/step strobes; it contains no arithmetic datapath.

Parameters:
- N_ITER, 16, number of CORDIC micro-rotations per operation (legal range 1..31).
- IDX_W, 5, width of the iteration index; must satisfy 2^IDX_W > N_ITER.
- ANGLE_W, 21, width of the fixed-point angle returned by the subtract stage.
- RES_W, 32, width of the float result.

Ports:
- clk, in, 1: system clock; all state changes on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- clk_en, in, 1: custom-instruction clock enable; the FSM advances only while it is high.
- start, in, 1: operation request; sampled only when clk_en=1.
- dataa, in, 32: IEEE-754 single operand.
- done, out, 1: one-cycle pulse marking result valid.
- result, out, RES_W: captured cosine result; holds until the next capture.
- busy, out, 1: high in every state except IDLE.
- conv_in, out, 32: latched operand driven to the float-to-fixed converter.
- conv_angle, in, ANGLE_W: combinational angle from the fixed_subtract chain.
- core_load, out, 1: one-cycle pulse that loads core_angle into the CORDIC core.
- core_angle, out, ANGLE_W: registered angle.
- core_step, out, 1: high for exactly N_ITER enabled cycles; each high cycle advances the core one iteration.
- core_iter, out, IDX_W: index of the iteration being performed, 0..N_ITER-1.
- core_cos, in, RES_W: core output, valid the cycle after the last step.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. done=0, result=0, busy=0, conv_in=0, core_angle=0, core_load=0, core_step=0, core_iter=0. Reset asserted mid-operation aborts the operation; no done is emitted for it.
- FSM states: IDLE, CONV, LOAD, ITER, FINISH. Each transition occurs only on a rising edge with clk_en=1.
- IDLE: on start=1, latch conv_in<=dataa and go to CONV. Otherwise stay in IDLE.
- CONV: register core_angle<=conv_angle, then go to LOAD. This allows one full cycle of combinational conversion.
- LOAD: core_load=1 for this cycle, core_iter<=0, then go to ITER.
- ITER: core_step=1. core_iter increments each enabled cycle. When core_iter==N_ITER-1, go to FINISH and hold core_iter at N_ITER-1.
- FINISH: capture result<=core_cos. Assert done=1 in the following cycle, which is IDLE.
- Latency: start is sampled at edge E0. done is high in the cycle after edge E0+N_ITER+3, assuming clk_en stays high throughout. With the default N_ITER=16, done rises at edge 19.
- Strobes (core_load, core_step, done) are registered Moore outputs. Each is forced 0 while clk_en=0.
- clk_en=0 mid-operation: state, core_iter, conv_in and core_angle freeze. On resume, the sequence continues with no step repeated or lost. Total step count is always exactly N_ITER.
- start while busy=1 is ignored and dataa is not re-latched. This includes start in the FINISH cycle.
- start in the same cycle that done=1 (state IDLE) is accepted and begins a new operation. result retains its previous value until the next FINISH.
- start with clk_en=0 is ignored.

Test Plan:
- Reset check: hold reset=0 for 3 cycles while start=1 and clk_en=1 -> all outputs 0, busy=0, no core_load.
- Single operation: dataa=32'h42c80000, stub conv_angle=21'h004000, core_cos=32'h3f800000 -> conv_in=42c80000, core_angle=004000, one core_load, 16 core_step cycles with core_iter 0..15, done at edge 19, result=3f800000.
- clk_en gap: same as the single operation but with clk_en=0 for 4 cycles during iteration 7 -> steps pause at core_iter=7, total steps still 16, done at edge 23.
- Busy collision: second start with dataa=32'h437f0000 at edge 5 -> ignored, conv_in stays 42c80000, exactly one done.
- Back-to-back: start asserted again in the done cycle with dataa=32'h41c80000 and stub core_cos=32'h43deea9d -> second operation runs, first result 3f800000 holds until the second done, then result=43deea9d.
- Mid-op reset: reset=0 at edge 10 -> immediate IDLE, all outputs 0, no done; the next start completes normally.
